// File: rtl/rvfi_mon_pkg.sv
// rvfi_mon_pkg
// Shared types and constants for the RVFI multi-lane retire monitor:
//   err_code_e  - error codes reported on errcode (NONE .. PC_CHAIN)
//   seg_state_e - segment FSM encoding reported on seg_state
//   halt / segment-marker instruction words and a halt-match helper.
package rvfi_mon_pkg;

   typedef enum logic [2:0] {
      NONE           = 3'd0,
      VALID_X        = 3'd1,
      LANE_GAP       = 3'd2,
      ORDER_MISMATCH = 3'd3,
      HALT_COMMIT    = 3'd4,
      PC_CHAIN       = 3'd5
   } err_code_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seg_state_e;

   // Self-loops (beq x0,x0,0 / jal x0,0) and the explicit halt marker.
   localparam logic [31:0] HALT_INST_BEQ  = 32'h0000_0063;
   localparam logic [31:0] HALT_INST_JAL  = 32'h0000_006f;
   localparam logic [31:0] HALT_INST_MARK = 32'hF000_2013;

   // Segment markers are slti x0 hints: architecturally no-ops.
   localparam logic [31:0] SEG_START_INST = 32'h0010_2013;
   localparam logic [31:0] SEG_STOP_INST  = 32'h0020_2013;

   function automatic logic is_halt_inst(input logic [31:0] word);
      return (word == HALT_INST_BEQ) || (word == HALT_INST_JAL) ||
             (word == HALT_INST_MARK);
   endfunction

endpackage

// File: rtl/rvfi_lane_decode.sv
// rvfi_lane_decode
// Per-lane combinational decode for one RVFI commit lane.
// Ports:
//   valid              - lane commit strobe (may carry X/Z in simulation)
//   order              - lane retire order, ORDER_W bits
//   inst               - lane instruction word
//   pc_rdata/pc_wdata  - lane PC before / after the commit
//   lane_valid         - lane definitely committed (valid is a known 1)
//   x_err              - X/Z on valid, or on the payload of a committing lane
//   halt_hit           - committing lane is a halt (self-loop PC or halt inst)
//   start_hit/stop_hit - committing lane carries a segment start/stop marker
module rvfi_lane_decode
   import rvfi_mon_pkg::*;
#(
   parameter int ORDER_W = 64
)(
   input  logic               valid,
   input  logic [ORDER_W-1:0] order,
   input  logic [31:0]        inst,
   input  logic [31:0]        pc_rdata,
   input  logic [31:0]        pc_wdata,
   output logic               lane_valid,
   output logic               x_err,
   output logic               halt_hit,
   output logic               start_hit,
   output logic               stop_hit
);

   logic payload_x;

   always_comb begin
      lane_valid = (valid === 1'b1);
      payload_x  = $isunknown(order) || $isunknown(inst) ||
                   $isunknown(pc_rdata) || $isunknown(pc_wdata);
      x_err      = $isunknown(valid) || (lane_valid && payload_x);
      // Unknown payloads must not leak X into the sticky halt or the FSM.
      halt_hit   = lane_valid && !payload_x &&
                   ((pc_rdata == pc_wdata) || is_halt_inst(inst));
      start_hit  = lane_valid && !payload_x && (inst == SEG_START_INST);
      stop_hit   = lane_valid && !payload_x && (inst == SEG_STOP_INST);
   end

endmodule

// File: rtl/rvfi_nret_monitor.sv
// rvfi_nret_monitor
// Checks an NRET-lane RVFI retire stream (lane contiguity, retire order,
// commits after halt, X on the interface) and counts instructions/cycles
// inside a start/stop marked segment.
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   valid                - per-lane commit strobe
//   order                - per-lane retire order, lane i at [i*ORDER_W +: ORDER_W]
//   inst                 - per-lane instruction word, lane i at [i*32 +: 32]
//   pc_rdata, pc_wdata   - per-lane PC before / after the commit
//   halt                 - sticky, set the cycle after a halting commit
//   error                - sticky, set the cycle after the first detected error
//   errcode, err_lane    - code and lane of that first error
//   seg_state            - segment FSM state
//   inst_count           - saturating retired-instruction count for the segment
//   cycle_count          - saturating cycle count for the segment
// Build option:
//   RVFI_PC_CHAIN_CHECK_EN - when defined, each commit's pc_rdata must equal
//                            the pc_wdata of the previous commit (code PC_CHAIN).
//
// Segment FSM
//   state | meaning
//   IDLE  | no segment started; counters run freely since reset
//   RUN   | inside a segment; counters run
//   DONE  | segment stopped; counters frozen until a new start or reset
module rvfi_nret_monitor
   import rvfi_mon_pkg::*;
#(
   parameter int NRET    = 2,
   parameter int ORDER_W = 64,
   parameter int CNT_W   = 64
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NRET-1:0]         valid,
   input  logic [NRET*ORDER_W-1:0] order,
   input  logic [NRET*32-1:0]      inst,
   input  logic [NRET*32-1:0]      pc_rdata,
   input  logic [NRET*32-1:0]      pc_wdata,
   output logic                    halt,
   output logic                    error,
   output logic [2:0]              errcode,
   output logic [$clog2(NRET):0]   err_lane,
   output logic [1:0]              seg_state,
   output logic [CNT_W-1:0]        inst_count,
   output logic [CNT_W-1:0]        cycle_count
);

   localparam int LW = $clog2(NRET) + 1;

   logic [NRET-1:0] lane_vld;
   logic [NRET-1:0] lane_x;
   logic [NRET-1:0] lane_halt;
   logic [NRET-1:0] lane_start;
   logic [NRET-1:0] lane_stop;

   for (genvar g = 0; g < NRET; g++) begin : g_lane
      rvfi_lane_decode #(.ORDER_W(ORDER_W)) u_dec (
         .valid      (valid[g]),
         .order      (order[g*ORDER_W +: ORDER_W]),
         .inst       (inst[g*32 +: 32]),
         .pc_rdata   (pc_rdata[g*32 +: 32]),
         .pc_wdata   (pc_wdata[g*32 +: 32]),
         .lane_valid (lane_vld[g]),
         .x_err      (lane_x[g]),
         .halt_hit   (lane_halt[g]),
         .start_hit  (lane_start[g]),
         .stop_hit   (lane_stop[g])
      );
   end

   logic               halt_q;
   logic               error_q;
   err_code_e          errcode_q;
   logic [LW-1:0]      err_lane_q;
   logic [ORDER_W-1:0] exp_order_q;
   seg_state_e         state_q, state_d;
   logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
   logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;

`ifdef RVFI_PC_CHAIN_CHECK_EN
   logic [31:0] last_pc_q;
   logic        last_pc_vld_q;
   logic [31:0] chain_pc;
   logic        chain_vld;
`endif

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // ---------------------------------------------------------------- checks
   err_code_e     lane_code [NRET];
   logic [LW-1:0] pop;
   logic          gap_seen;
   logic          halt_pend;
   logic          first_hit;
   err_code_e     first_code;
   logic [LW-1:0] first_lane;

   always_comb begin
      gap_seen   = 1'b0;
      halt_pend  = halt_q;
      pop        = '0;
      first_hit  = 1'b0;
      first_code = NONE;
      first_lane = '0;
`ifdef RVFI_PC_CHAIN_CHECK_EN
      chain_pc   = last_pc_q;
      chain_vld  = last_pc_vld_q;
`endif
      for (int i = 0; i < NRET; i++) begin
         // Codes are tested lowest first so each lane reports its lowest code.
         lane_code[i] = NONE;
         if (lane_x[i]) begin
            lane_code[i] = VALID_X;
         end else if (lane_vld[i]) begin
            if (gap_seen)
               lane_code[i] = LANE_GAP;
            else if (order[i*ORDER_W +: ORDER_W] != exp_order_q + ORDER_W'(i))
               lane_code[i] = ORDER_MISMATCH;
            else if (halt_pend)
               lane_code[i] = HALT_COMMIT;
`ifdef RVFI_PC_CHAIN_CHECK_EN
            else if (chain_vld && (pc_rdata[i*32 +: 32] != chain_pc))
               lane_code[i] = PC_CHAIN;
`endif
         end

         if (lane_vld[i]) begin
            pop = pop + LW'(1);
`ifdef RVFI_PC_CHAIN_CHECK_EN
            chain_pc  = pc_wdata[i*32 +: 32];
            chain_vld = 1'b1;
`endif
         end else begin
            gap_seen = 1'b1;
         end

         // The halting lane itself is legal; only younger lanes see it.
         halt_pend = halt_pend | lane_halt[i];

         if (!first_hit && (lane_code[i] != NONE)) begin
            first_hit  = 1'b1;
            first_code = lane_code[i];
            first_lane = LW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halt_q      <= 1'b0;
         error_q     <= 1'b0;
         errcode_q   <= NONE;
         err_lane_q  <= '0;
         exp_order_q <= '0;
      end else begin
         halt_q      <= halt_q | (|lane_halt);
         exp_order_q <= exp_order_q + ORDER_W'(pop);
         if (!error_q && first_hit) begin
            error_q    <= 1'b1;
            errcode_q  <= first_code;
            err_lane_q <= first_lane;
         end
      end
   end

`ifdef RVFI_PC_CHAIN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_pc_q     <= '0;
         last_pc_vld_q <= 1'b0;
      end else begin
         last_pc_q     <= chain_pc;
         last_pc_vld_q <= chain_vld;
      end
   end
`endif

   // ------------------------------------------------------- segment decode
   int            start_idx;
   int            stop_idx;
   logic [LW-1:0] above_cnt;
   logic [LW-1:0] upto_cnt;

   always_comb begin
      start_idx = -1;
      stop_idx  = -1;
      above_cnt = '0;
      upto_cnt  = '0;
      // The youngest start wins: it restarts the segment last.
      for (int i = 0; i < NRET; i++)
         if (lane_start[i]) start_idx = i;
      // The oldest stop ends the segment.
      for (int i = NRET - 1; i >= 0; i--)
         if (lane_stop[i]) stop_idx = i;
      for (int i = 0; i < NRET; i++) begin
         if (lane_vld[i] && (start_idx >= 0) && (i > start_idx))
            above_cnt = above_cnt + LW'(1);
         if (lane_vld[i] && (stop_idx >= 0) && (i <= stop_idx))
            upto_cnt = upto_cnt + LW'(1);
      end
   end

   // ---------------------------------------------------------- segment FSM
   always_comb begin
      state_d    = state_q;
      inst_cnt_d = inst_cnt_q;
      cyc_cnt_d  = cyc_cnt_q;
      if (start_idx >= 0) begin
         // Start overrides any stop in the same cycle.
         state_d    = RUN;
         cyc_cnt_d  = '0;
         inst_cnt_d = CNT_W'(above_cnt);
      end else begin
         case (state_q)
            IDLE: begin
               cyc_cnt_d  = sat_add(cyc_cnt_q, CNT_W'(1));
               inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(pop));
            end
            RUN: begin
               cyc_cnt_d = sat_add(cyc_cnt_q, CNT_W'(1));
               if (stop_idx >= 0) begin
                  state_d    = DONE;
                  inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(upto_cnt));
               end else begin
                  inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(pop));
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         inst_cnt_q <= '0;
         cyc_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         inst_cnt_q <= inst_cnt_d;
         cyc_cnt_q  <= cyc_cnt_d;
      end
   end

   assign halt        = halt_q;
   assign error       = error_q;
   assign errcode     = errcode_q;
   assign err_lane    = err_lane_q;
   assign seg_state   = state_q;
   assign inst_count  = inst_cnt_q;
   assign cycle_count = cyc_cnt_q;

endmodule

// File: tb/tb_rvfi_nret_monitor.sv
`timescale 1ns/1ps
module tb_rvfi_nret_monitor;

   localparam int NRET    = 2;
   localparam int ORDER_W = 8;
   localparam int CNT_W   = 8;
   localparam int LW      = $clog2(NRET) + 1;
   localparam int OMOD    = 1 << ORDER_W;
   localparam int CMAX    = (1 << CNT_W) - 1;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] START = 32'h0010_2013;
   localparam logic [31:0] STOP  = 32'h0020_2013;
   localparam logic [31:0] JAL0  = 32'h0000_006f;
   localparam logic [31:0] BEQ0  = 32'h0000_0063;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NRET-1:0]         valid;
   logic [NRET*ORDER_W-1:0] order;
   logic [NRET*32-1:0]      inst, pc_rdata, pc_wdata;
   logic                    halt, error;
   logic [2:0]              errcode;
   logic [LW-1:0]           err_lane;
   logic [1:0]              seg_state;
   logic [CNT_W-1:0]        inst_count, cycle_count;

   rvfi_nret_monitor #(.NRET(NRET), .ORDER_W(ORDER_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .valid(valid), .order(order), .inst(inst),
      .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .halt(halt), .error(error),
      .errcode(errcode), .err_lane(err_lane), .seg_state(seg_state),
      .inst_count(inst_count), .cycle_count(cycle_count));

   always #5 clk = ~clk;

   typedef struct {
      bit halt; bit err; int code; int lane; int seg; int ic; int cc;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // stimulus for the next cycle
   bit          s_rst;
   bit          s_v   [NRET];
   int unsigned s_ord [NRET];
   int unsigned s_inst[NRET];
   int unsigned s_pcr [NRET];
   int unsigned s_pcw [NRET];
   int unsigned b_pc = 32'h1000;

   // reference model state
   bit m_halt, m_err, m_lpv;
   int m_code, m_lane, m_exp, m_seg, m_ic, m_cc;
   int unsigned m_lpc;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   function automatic bit halt_word(input int unsigned w);
      return (w == BEQ0) || (w == JAL0) || (w == 32'hF000_2013);
   endfunction

   // Model: derived directly from the rules on a whole-cycle basis.
   task automatic model_step();
      int vmask, p, code, fc, fl, start, stop;
      bit hb, fh, cv;
      int unsigned cpc;
      if (s_rst) begin
         m_halt = 0; m_err = 0; m_code = 0; m_lane = 0; m_exp = 0;
         m_seg = 0; m_ic = 0; m_cc = 0; m_lpv = 0; m_lpc = 0;
      end else begin
         vmask = 0;
         for (int i = 0; i < NRET; i++) if (s_v[i]) vmask |= (1 << i);
         p = $countones(vmask);
         hb = m_halt; fh = 0; fc = 0; fl = 0; start = -1; stop = -1;
         cv = m_lpv; cpc = m_lpc;
         for (int i = 0; i < NRET; i++) begin
            if (!s_v[i]) continue;
            code = 0;
            if ((vmask & ((1 << i) - 1)) != ((1 << i) - 1)) code = 2;
            else if (s_ord[i] != (m_exp + i) % OMOD) code = 3;
            else if (hb) code = 4;
`ifdef RVFI_PC_CHAIN_CHECK_EN
            else if (cv && s_pcr[i] != cpc) code = 5;
`endif
            cv = 1; cpc = s_pcw[i];
            if (code != 0 && !fh) begin fh = 1; fc = code; fl = i; end
            if (s_pcr[i] == s_pcw[i] || halt_word(s_inst[i])) hb = 1;
            if (s_inst[i] == START) start = i;
            if (s_inst[i] == STOP && stop < 0) stop = i;
         end
         if (!m_err && fh) begin m_err = 1; m_code = fc; m_lane = fl; end
         m_halt = hb;
         m_exp  = (m_exp + p) % OMOD;
         m_lpv  = cv; m_lpc = cpc;
         if (start >= 0) begin
            m_seg = 1; m_cc = 0; m_ic = $countones(vmask >> (start + 1));
         end else if (m_seg != 2) begin
            m_cc = sat(m_cc + 1);
            if (m_seg == 1 && stop >= 0) begin
               m_ic = sat(m_ic + $countones(vmask & ((2 << stop) - 1)));
               m_seg = 2;
            end else begin
               m_ic = sat(m_ic + p);
            end
         end
      end
   endtask

   task automatic apply_cycle();
      exp_t e;
      @(negedge clk);
      rst = s_rst;
      for (int i = 0; i < NRET; i++) begin
         valid[i] = s_v[i];
         order[i*ORDER_W +: ORDER_W] = ORDER_W'(s_ord[i]);
         inst[i*32 +: 32]     = s_inst[i];
         pc_rdata[i*32 +: 32] = s_pcr[i];
         pc_wdata[i*32 +: 32] = s_pcw[i];
      end
      model_step();
      e.halt = m_halt; e.err = m_err; e.code = m_code; e.lane = m_lane;
      e.seg = m_seg; e.ic = m_ic; e.cc = m_cc;
      sb_q.push_back(e);
   endtask

   task automatic clear_lanes();
      s_rst = 0;
      for (int i = 0; i < NRET; i++) begin
         s_v[i] = 0; s_ord[i] = $urandom; s_inst[i] = $urandom;
         s_pcr[i] = $urandom; s_pcw[i] = $urandom;
      end
   endtask

   task automatic legal_lane(input int i, input int unsigned w);
      s_v[i] = 1; s_ord[i] = (m_exp + i) % OMOD; s_inst[i] = w;
      s_pcr[i] = b_pc; s_pcw[i] = b_pc + 4; b_pc += 4;
   endtask

   task automatic pair(input int unsigned w0, input int unsigned w1);
      clear_lanes(); legal_lane(0, w0); legal_lane(1, w1); apply_cycle();
   endtask

   task automatic do_reset(input int n);
      clear_lanes(); s_rst = 1;
      repeat (n) apply_cycle();
      s_rst = 0;
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   function automatic int unsigned pick_inst();
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) return START;
      if (r == 1) return STOP;
      if (r == 2) return JAL0;
      return $urandom;
   endfunction

   task automatic rand_cycles(input int n);
      int np, r;
      for (int c = 0; c < n; c++) begin
         clear_lanes();
         np = $urandom_range(0, NRET);
         for (int i = 0; i < np; i++) legal_lane(i, pick_inst());
         r = $urandom_range(0, 31);
         if (r == 0 && np == NRET) s_v[0] = 0;
         if (r == 1 && np > 0) s_ord[np-1] = s_ord[np-1] ^ 1;
         if (r == 2 && np > 0) s_pcr[0] = s_pcr[0] ^ 4;
         apply_cycle();
      end
   endtask

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_halt", halt, e.halt);
            chk("sb_error", error, e.err);
            if (e.err) begin
               chk("sb_errcode", errcode, e.code);
               chk("sb_err_lane", err_lane, e.lane);
            end
            chk("sb_seg_state", seg_state, e.seg);
            chk("sb_inst_count", inst_count, e.ic);
            chk("sb_cycle_count", cycle_count, e.cc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; valid = '0; order = '0; inst = '0; pc_rdata = '0; pc_wdata = '0;
      do_reset(2);
      settle();
      chk("rst_seg", seg_state, 0);
      chk("rst_inst_count", inst_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_error", error, 0);
      chk("rst_halt", halt, 0);

      // orders 0/1 then 2/3, then 4/5 proves exp_order reached 4
      pair(NOP, NOP); pair(NOP, NOP); pair(NOP, NOP);
      settle();
      chk("order_seq_error", error, 0);
      chk("idle_inst_count", inst_count, 6);

      // valid = 10 with order 0 on lane 1
      do_reset(1);
      clear_lanes(); s_v[1] = 1; s_ord[1] = 0; s_inst[1] = NOP;
      s_pcr[1] = b_pc; s_pcw[1] = b_pc + 4; apply_cycle();
      settle();
      chk("gap_error", error, 1);
      chk("gap_errcode", errcode, 2);
      chk("gap_err_lane", err_lane, 1);

      // segment: start, 9 full cycles, stop on lane 0
      do_reset(1);
      pair(START, NOP);
      repeat (9) pair(NOP, NOP);
      pair(STOP, NOP);
      settle();
      chk("seg_done_state", seg_state, 2);
      chk("seg_inst_count", inst_count, 20);
      chk("seg_cycle_count", cycle_count, 10);
      pair(NOP, NOP);
      settle();
      chk("seg_frozen_cycles", cycle_count, 10);
      chk("seg_frozen_insts", inst_count, 20);
      pair(NOP, START);
      settle();
      chk("restart_state", seg_state, 1);
      chk("restart_inst_count", inst_count, 0);
      pair(START, STOP);
      settle();
      chk("start_wins_state", seg_state, 1);
      chk("start_wins_inst_count", inst_count, 1);
      do_reset(1);
      settle();
      chk("midseg_rst_state", seg_state, 0);
      chk("midseg_rst_cycles", cycle_count, 0);

      // halt then a commit
      do_reset(1);
      clear_lanes(); legal_lane(0, JAL0); apply_cycle();
      settle();
      chk("halt_set", halt, 1);
      chk("halt_no_error", error, 0);
      clear_lanes(); legal_lane(0, NOP); apply_cycle();
      settle();
      chk("halt_commit_errcode", errcode, 4);
      chk("halt_commit_lane", err_lane, 0);

      // younger lane in the halting cycle
      do_reset(1);
      pair(BEQ0, NOP);
      settle();
      chk("halt_same_cycle_code", errcode, 4);
      chk("halt_same_cycle_lane", err_lane, 1);

      // order wrap: exp_order to 255, then 255/0
      do_reset(1);
      repeat (127) pair(NOP, NOP);
      clear_lanes(); legal_lane(0, NOP); apply_cycle();
      clear_lanes(); legal_lane(0, NOP); legal_lane(1, NOP);
      s_ord[0] = 255; s_ord[1] = 0; apply_cycle();
      settle();
      chk("order_wrap_error", error, 0);

      // broken PC chain between lanes
      do_reset(1);
      clear_lanes(); legal_lane(0, NOP); legal_lane(1, NOP);
      s_pcr[0] = 32'hFC; s_pcw[0] = 32'h100; s_pcr[1] = 32'h104; s_pcw[1] = 32'h108;
      apply_cycle();
      settle();
`ifdef RVFI_PC_CHAIN_CHECK_EN
      chk("pc_chain_errcode", errcode, 5);
      chk("pc_chain_lane", err_lane, 1);
`else
      chk("pc_chain_disabled", error, 0);
`endif

      // counter saturation
      do_reset(1);
      repeat (300) pair(NOP, NOP);
      settle();
      chk("sat_cycle_count", cycle_count, CMAX);
      chk("sat_inst_count", inst_count, CMAX);

      // randomized blocks
      for (int b = 0; b < 8; b++) begin
         do_reset($urandom_range(1, 2));
         rand_cycles(50);
      end

      clear_lanes(); apply_cycle();
      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
